// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS pipeline.
// It detects load-use hazards and holds the front end. It resolves taken EX-stage
// branches and ID-stage jumps with flushes. It also keeps saturating stall/flush
// performance counters. Control outputs are Mealy: they come from the current state
// and the current inputs.
module hazard_control_unit #(
   parameter int REG_W               = 5,
   parameter int DATA_W              = 32,
   parameter int LOAD_STALL_CYCLES   = 1,
   parameter int BRANCH_FLUSH_CYCLES = 1,
   parameter int CNT_W               = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  rs_id,
   input  logic [REG_W-1:0]  rt_id,
   input  logic              rs_used_id,
   input  logic              rt_used_id,
   input  logic [REG_W-1:0]  rt_ex,
   input  logic              mem_read_ex,
   input  logic              branch_eq_ex,
   input  logic              branch_ne_ex,
   input  logic              regs_equal_ex,
   input  logic [DATA_W-1:0] branch_offset_ex,
   input  logic              jump_id,
   input  logic              clear_counters,
   output logic              hold_pc,
   output logic              hold_if_id,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              take_branch,
   output logic [DATA_W-1:0] pc_offset,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_cycles,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_LOAD_STALL = 2'd1,
      S_FLUSH      = 2'd2
   } state_t;

   // Remaining-cycle reload values. The first cycle of each action is spent in IDLE.
   localparam logic [3:0]       LOAD_REM = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [3:0]       BR_REM   = 4'(BRANCH_FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t            state_q, state_d;
   logic [3:0]        rem_q, rem_d;
   logic [CNT_W-1:0]  stall_q, flush_q;

   logic              load_hz_s, br_tk_s;
   logic              hold_pc_s, hold_if_id_s, flush_if_id_s, flush_id_ex_s, take_branch_s;
   logic [DATA_W-1:0] pc_offset_s;

   // A load into $0 can never create a real dependency, so it is excluded here.
   assign load_hz_s = mem_read_ex & (rt_ex != {REG_W{1'b0}}) &
                      ((rs_used_id & (rs_id == rt_ex)) | (rt_used_id & (rt_id == rt_ex)));
   assign br_tk_s   = (branch_eq_ex & regs_equal_ex) | (branch_ne_ex & ~regs_equal_ex);

   // Next-state and Mealy output decode. A taken branch may abort a load stall.
   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      hold_pc_s     = 1'b0;
      hold_if_id_s  = 1'b0;
      flush_if_id_s = 1'b0;
      flush_id_ex_s = 1'b0;
      take_branch_s = 1'b0;
      pc_offset_s   = {DATA_W{1'b0}};
      if (rst) begin
         state_d = S_IDLE;
         rem_d   = 4'd0;
      end else begin
         case (state_q)
            S_IDLE, S_LOAD_STALL: begin
               if (br_tk_s) begin
                  take_branch_s = 1'b1;
                  pc_offset_s   = branch_offset_ex;
                  flush_if_id_s = 1'b1;
                  flush_id_ex_s = 1'b1;
                  if (BRANCH_FLUSH_CYCLES > 1) begin
                     state_d = S_FLUSH;
                     rem_d   = BR_REM;
                  end else begin
                     state_d = S_IDLE;
                     rem_d   = 4'd0;
                  end
               end else if (state_q == S_LOAD_STALL) begin
                  hold_pc_s     = 1'b1;
                  hold_if_id_s  = 1'b1;
                  flush_id_ex_s = 1'b1;
                  if (rem_q <= 4'd1) begin
                     state_d = S_IDLE;
                     rem_d   = 4'd0;
                  end else begin
                     rem_d = rem_q - 4'd1;
                  end
               end else if (load_hz_s) begin
                  hold_pc_s     = 1'b1;
                  hold_if_id_s  = 1'b1;
                  flush_id_ex_s = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = S_LOAD_STALL;
                     rem_d   = LOAD_REM;
                  end else begin
                     state_d = S_IDLE;
                     rem_d   = 4'd0;
                  end
               end else if (jump_id) begin
                  flush_if_id_s = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FLUSH: begin
               flush_if_id_s = 1'b1;
               flush_id_ex_s = 1'b1;
               if (rem_q <= 4'd1) begin
                  state_d = S_IDLE;
                  rem_d   = 4'd0;
               end else begin
                  rem_d = rem_q - 4'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               rem_d   = 4'd0;
            end
         endcase
      end
   end

   // State and remaining-cycle registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // Saturating performance counters; a clear wins over an increment.
   always_ff @(posedge clk) begin
      if (rst || clear_counters) begin
         stall_q <= {CNT_W{1'b0}};
         flush_q <= {CNT_W{1'b0}};
      end else begin
         if (hold_pc_s && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_q <= stall_q;
         end
         if (flush_if_id_s && (flush_q != CNT_MAX)) begin
            flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_q <= flush_q;
         end
      end
   end

   assign hold_pc      = hold_pc_s;
   assign hold_if_id   = hold_if_id_s;
   assign flush_if_id  = flush_if_id_s;
   assign flush_id_ex  = flush_id_ex_s;
   assign take_branch  = take_branch_s;
   assign pc_offset    = pc_offset_s;
   assign stall_cycles = stall_q;
   assign flush_cycles = flush_q;
   assign busy         = (state_q != S_IDLE) & ~rst;

endmodule
